msg_scroller: RTL

MSG_SCROLLER -- requirements
Module: msg_scroller

---
 rtl/msg_scroller_pkg.sv | 15 +
 rtl/msg_scroller_idx_mod.sv | 24 ++
 rtl/msg_scroller.sv | 134 +++++++++++++
 3 files changed

// File: rtl/msg_scroller_pkg.sv
// Shared types and constants for the scrolling hex-message display.
// Holds the FSM encoding and the default buffer geometry.
package msg_scroller_pkg;

    localparam int MSG_DEPTH = 16;
    localparam int DIGIT_W   = 4;
    localparam int WINDOW    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/msg_scroller_idx_mod.sv
// Small modulo adder: (base + offset) mod len for base < len and offset 0..3.
// Uses three conditional subtractions instead of a divider.
module idx_mod #(
    parameter int AW = 4
) (
    input  logic [AW-1:0] base,
    input  logic [1:0]    offset,
    input  logic [AW:0]   len,
    output logic [AW-1:0] result
);

    logic [AW:0] s0;
    logic [AW:0] s1;
    logic [AW:0] s2;

    // base < len, so the sum is below len + 3; three subtractions cover len == 1.
    always_comb begin
        s0     = {1'b0, base} + {{(AW - 1){1'b0}}, offset};
        s1     = (s0 >= len) ? (s0 - len) : s0;
        s2     = (s1 >= len) ? (s1 - len) : s1;
        result = (s2 >= len) ? AW'(s2 - len) : s2[AW-1:0];
    end

endmodule

// File: rtl/msg_scroller.sv
// Scrolls a four-digit window across a hex-digit message buffer on each tick.
// The window is purely combinational from registered buffer, pointer and length.
module msg_scroller
    import msg_scroller_pkg::*;
#(
    parameter int MSG_DEPTH = msg_scroller_pkg::MSG_DEPTH,
    parameter int DIGIT_W   = msg_scroller_pkg::DIGIT_W
) (
    input  logic                                   clk,
    input  logic                                   rst_L,
    input  logic                                   tick,
    input  logic                                   run,
    input  logic                                   clr,
    input  logic                                   dir,
    input  logic                                   wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0]           wr_addr,
    input  logic [DIGIT_W-1:0]                     wr_data,
    input  logic [$clog2(MSG_DEPTH):0]             len,
    output logic [msg_scroller_pkg::WINDOW*DIGIT_W-1:0] value,
    output logic                                   busy,
    output logic                                   wrap
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;

    state_t           state_reg;
    state_t           state_next;
    logic [AW-1:0]    ptr_reg;
    logic [AW-1:0]    ptr_next;
    logic [AW-1:0]    ptr_inc;
    logic [AW-1:0]    ptr_dec;
    logic [AW:0]      len_q_reg;
    logic [AW:0]      len_q_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             advance;
    logic [DIGIT_W-1:0] msg_buf_reg [MSG_DEPTH];
    logic [AW-1:0]    win_idx [WINDOW];

    function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
        return (l > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : l;
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (run && (len != '0)) state_next = RUN;
                RUN:     if (!run) state_next = HOLD;
                HOLD:    if (run) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_reg == RUN) || (state_reg == HOLD);
    end

    // ---------------- Pointer, length, wrap ----------------
    // A tick coinciding with the falling edge of run is dropped, so run gates it here.
    always_comb begin
        advance    = !clr && (state_reg == RUN) && run && tick;
        ptr_dec    = (ptr_reg == '0) ? AW'(len_q_reg - 1'b1) : (ptr_reg - 1'b1);
        ptr_next   = ptr_reg;
        if (clr || (state_reg == IDLE)) begin
            ptr_next = '0;
        end else if (advance) begin
            ptr_next = dir ? ptr_dec : ptr_inc;
        end
        // A zero length keeps the last usable length so the window never divides by zero.
        len_q_next = len_q_reg;
        if ((state_reg == IDLE) && (len != '0)) begin
            len_q_next = clamp_len(len);
        end
        wrap_next  = advance && (ptr_next == '0) && (ptr_reg != '0);
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            ptr_reg   <= '0;
            len_q_reg <= LW'(4);
            wrap_reg  <= 1'b0;
        end else begin
            ptr_reg   <= ptr_next;
            len_q_reg <= len_q_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign wrap = wrap_reg;

    idx_mod #(.AW(AW)) u_ptr_inc (
        .base   (ptr_reg),
        .offset (2'd1),
        .len    (len_q_reg),
        .result (ptr_inc)
    );

    // ---------------- Message buffer ----------------
    for (genvar gi = 0; gi < MSG_DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk or negedge rst_L) begin
            if (!rst_L) begin
                msg_buf_reg[gi] <= '0;
            end else if (wr_en && (wr_addr == AW'(gi))) begin
                msg_buf_reg[gi] <= wr_data;
            end
        end
    end

    // ---------------- Display window ----------------
    for (genvar gi = 0; gi < WINDOW; gi++) begin : g_win
        idx_mod #(.AW(AW)) u_win_idx (
            .base   (ptr_reg),
            .offset (2'(gi)),
            .len    (len_q_reg),
            .result (win_idx[gi])
        );
        assign value[(WINDOW-1-gi)*DIGIT_W +: DIGIT_W] = msg_buf_reg[win_idx[gi]];
    end

endmodule
